// File: rtl/pcie_gen5_tl_requester.sv
// Requester-side PCIe transaction layer: builds MemWr/MemRd headers, allocates
// tags, matches returning Cpl/CplD and reports data, acks and completion timeouts.
module pcie_gen5_tl_requester #(
    parameter int          ADDR_WIDTH       = 64,
    parameter int          DATA_WIDTH       = 256,
    parameter int          TLP_HEADER_WIDTH = 128,
    parameter int          NUM_TAGS         = 8,
    parameter int          CPL_TIMEOUT      = 1024,
    parameter logic [15:0] REQUESTER_ID     = 16'h0100
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_is_write,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_data,
    input  logic [9:0]                     req_length,
    input  logic [3:0]                     req_first_be,
    input  logic [3:0]                     req_last_be,
    output logic                           tx_valid,
    output logic                           tx_sop,
    output logic                           tx_eop,
    output logic [TLP_HEADER_WIDTH-1:0]    tx_header,
    output logic [DATA_WIDTH-1:0]          tx_data,
    input  logic                           tx_ready,
    input  logic                           rx_valid,
    input  logic                           rx_sop,
    input  logic                           rx_eop,
    input  logic [TLP_HEADER_WIDTH-1:0]    rx_header,
    input  logic [DATA_WIDTH-1:0]          rx_data,
    output logic                           rsp_valid,
    output logic [9:0]                     rsp_tag,
    output logic [1:0]                     rsp_status,
    output logic                           rsp_is_write,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           err_unexp_cpl,
    output logic [$clog2(NUM_TAGS+1)-1:0]  outstanding_cnt
);

    localparam int         TAG_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int         TMR_W    = $clog2(CPL_TIMEOUT + 1);
    localparam int         CNT_W    = $clog2(NUM_TAGS + 1);
    localparam logic [2:0] FMT_NODATA = 3'b000;
    localparam logic [2:0] FMT_DATA   = 3'b010;
    localparam logic [4:0] TYPE_MEM   = 5'b00000;
    localparam logic [4:0] TYPE_CPL   = 5'b01010;

    typedef enum logic {
        TAG_FREE     = 1'b0,
        TAG_WAIT_CPL = 1'b1
    } tag_state_t;

    tag_state_t            r_state     [NUM_TAGS];
    tag_state_t            w_state_nxt [NUM_TAGS];
    logic [TMR_W-1:0]      r_timer     [NUM_TAGS];
    logic [TMR_W-1:0]      w_timer_nxt [NUM_TAGS];
    logic [NUM_TAGS-1:0]   r_is_write;

    logic                  r_tx_valid;
    logic [TLP_HEADER_WIDTH-1:0] r_tx_header;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_rsp_valid;
    logic [9:0]            r_rsp_tag;
    logic [1:0]            r_rsp_status;
    logic                  r_rsp_is_write;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_err_unexp_cpl;
    logic [CNT_W-1:0]      r_outstanding_cnt;

    logic                  w_any_free;
    logic [TAG_W-1:0]      w_alloc_tag;
    logic                  w_accept;
    logic [127:0]          w_tx_header;
    logic [2:0]            w_rx_fmt;
    logic [4:0]            w_rx_type;
    logic [9:0]            w_rx_tag;
    logic [TAG_W-1:0]      w_rx_tag_idx;
    logic                  w_is_cpl;
    logic                  w_cpl_match;
    logic                  w_to_any;
    logic [TAG_W-1:0]      w_to_tag;
    logic                  w_do_timeout;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_unused;

    // Lowest free tag wins: the descending loop lets the last hit overwrite.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_any_free  = 1'b0;
        w_alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (r_state[i] == TAG_FREE) begin
                w_any_free  = 1'b1;
                w_alloc_tag = TAG_W'(i);
            end
        end
    end

    assign req_ready = (!r_tx_valid || tx_ready) && w_any_free;
    assign w_accept  = req_valid && req_ready;

    assign w_tx_header = {req_is_write ? FMT_DATA : FMT_NODATA, TYPE_MEM,
                          3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0,
                          req_length, REQUESTER_ID, 10'(w_alloc_tag),
                          req_last_be, req_first_be, 64'(req_addr)};

    assign w_rx_fmt     = rx_header[127:125];
    assign w_rx_type    = rx_header[124:120];
    assign w_rx_tag     = rx_header[81:72];
    assign w_rx_tag_idx = w_rx_tag[TAG_W-1:0];
    assign w_is_cpl     = rx_valid && rx_sop && (w_rx_type == TYPE_CPL) &&
                          ((w_rx_fmt == FMT_NODATA) || (w_rx_fmt == FMT_DATA));
    // CplD must answer a read and Cpl must answer a write.
    assign w_cpl_match  = w_is_cpl && (w_rx_tag < 10'(NUM_TAGS)) &&
                          (r_state[w_rx_tag_idx] == TAG_WAIT_CPL) &&
                          ((w_rx_fmt == FMT_DATA) == !r_is_write[w_rx_tag_idx]);

    // A tag times out on the edge its timer reaches CPL_TIMEOUT; once saturated
    // it stays eligible until it wins the single response slot.
    always_comb begin
        w_to_any = 1'b0;
        w_to_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (r_state[i] == TAG_WAIT_CPL && r_timer[i] >= TMR_W'(CPL_TIMEOUT - 1)) begin
                w_to_any = 1'b1;
                w_to_tag = TAG_W'(i);
            end
        end
    end

    assign w_do_timeout = w_to_any && !w_cpl_match;

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            if (r_state[i] == TAG_WAIT_CPL && r_timer[i] != TMR_W'(CPL_TIMEOUT))
                w_timer_nxt[i] = r_timer[i] + 1'b1;
            if ((w_cpl_match && w_rx_tag_idx == TAG_W'(i)) ||
                (w_do_timeout && w_to_tag == TAG_W'(i))) begin
                w_state_nxt[i] = TAG_FREE;
                w_timer_nxt[i] = '0;
            end
            if (w_accept && w_alloc_tag == TAG_W'(i)) begin
                w_state_nxt[i] = TAG_WAIT_CPL;
                w_timer_nxt[i] = '0;
            end
            if (w_state_nxt[i] == TAG_WAIT_CPL)
                w_cnt_nxt = w_cnt_nxt + 1'b1;
        end
    end

    // NOTE: the per-tag tables are a handful of flops, so they take the reset
    // and a mid-operation reset drops every outstanding request cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_state[i] <= TAG_FREE;
                r_timer[i] <= '0;
            end
            r_is_write <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
            if (w_accept)
                r_is_write[w_alloc_tag] <= req_is_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_valid  <= 1'b0;
            r_tx_header <= '0;
            r_tx_data   <= '0;
        end else if (w_accept) begin
            r_tx_valid  <= 1'b1;
            r_tx_header <= w_tx_header;
            r_tx_data   <= req_is_write ? req_data : '0;
        end else if (tx_ready) begin
            r_tx_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid       <= 1'b0;
            r_rsp_tag         <= '0;
            r_rsp_status      <= '0;
            r_rsp_is_write    <= 1'b0;
            r_rsp_data        <= '0;
            r_err_unexp_cpl   <= 1'b0;
            r_outstanding_cnt <= '0;
        end else begin
            r_rsp_valid       <= w_cpl_match || w_do_timeout;
            r_err_unexp_cpl   <= w_is_cpl && !w_cpl_match;
            r_outstanding_cnt <= w_cnt_nxt;
            if (w_cpl_match) begin
                r_rsp_tag      <= w_rx_tag;
                r_rsp_status   <= 2'b00;
                r_rsp_is_write <= r_is_write[w_rx_tag_idx];
                r_rsp_data     <= (w_rx_fmt == FMT_DATA) ? rx_data : '0;
            end else if (w_do_timeout) begin
                r_rsp_tag      <= 10'(w_to_tag);
                r_rsp_status   <= 2'b01;
                r_rsp_is_write <= r_is_write[w_to_tag];
                r_rsp_data     <= '0;
            end
        end
    end

    assign tx_valid        = r_tx_valid;
    assign tx_sop          = r_tx_valid;
    assign tx_eop          = r_tx_valid;
    assign tx_header       = r_tx_header;
    assign tx_data         = r_tx_data;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_tag         = r_rsp_tag;
    assign rsp_status      = r_rsp_status;
    assign rsp_is_write    = r_rsp_is_write;
    assign rsp_data        = r_rsp_data;
    assign err_unexp_cpl   = r_err_unexp_cpl;
    assign outstanding_cnt = r_outstanding_cnt;

    // Completion length, requester ID and EOP carry no information for single-beat matching.
    assign w_unused = ^{rx_eop, rx_header[119:82], rx_header[71:0]};

endmodule

// File: tb/tb_pcie_gen5_tl_requester.sv
// Bench for pcie_gen5_tl_requester: table vectors, directed corner sequences and
// random traffic against a deadline-based model of tags and responses.
module tb_pcie_gen5_tl_requester;

    localparam int NT = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_is_write;
    logic [63:0]   req_addr;
    logic [255:0]  req_data;
    logic [9:0]    req_length;
    logic [3:0]    req_first_be, req_last_be;
    logic          tx_valid, tx_sop, tx_eop, tx_ready;
    logic [127:0]  tx_header;
    logic [255:0]  tx_data;
    logic          rx_valid, rx_sop, rx_eop;
    logic [127:0]  rx_header;
    logic [255:0]  rx_data;
    logic          rsp_valid, rsp_is_write, err_unexp_cpl;
    logic [9:0]    rsp_tag;
    logic [1:0]    rsp_status;
    logic [255:0]  rsp_data;
    logic [3:0]    outstanding_cnt;

    int total = 0;
    int bad   = 0;

    // Model: a tag is pending from its accept edge until answered; it expires at accept edge + TO.
    bit            m_pend [NT];
    int            m_alloc[NT];
    bit            m_wr   [NT];
    bit            m_txv;
    logic [127:0]  m_txh;
    logic [255:0]  m_txd;
    int            edge_no = 0;

    pcie_gen5_tl_requester #(.CPL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_data(req_data), .req_length(req_length),
        .req_first_be(req_first_be), .req_last_be(req_last_be),
        .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_header(tx_header), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_header(rx_header), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_status(rsp_status),
        .rsp_is_write(rsp_is_write), .rsp_data(rsp_data),
        .err_unexp_cpl(err_unexp_cpl), .outstanding_cnt(outstanding_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [127:0] mk_hdr(input bit wr, input logic [63:0] addr,
                                            input logic [9:0] len, input logic [3:0] fbe,
                                            input logic [3:0] lbe, input int tag);
        logic [127:0] h;
        h          = '0;
        h[127:125] = wr ? 3'b010 : 3'b000;
        h[107:98]  = len;
        h[97:82]   = 16'h0100;
        h[81:72]   = 10'(tag);
        h[71:68]   = lbe;
        h[67:64]   = fbe;
        h[63:0]    = addr;
        return h;
    endfunction

    function automatic logic [127:0] mk_cpl(input logic [2:0] fmt, input logic [4:0] typ, input int tag);
        logic [127:0] h;
        h          = '0;
        h[127:125] = fmt;
        h[124:120] = typ;
        h[107:82]  = 26'($urandom());
        h[81:72]   = 10'(tag);
        return h;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int t = 0; t < NT; t++) if (m_pend[t]) c++;
        return c;
    endfunction

    task automatic set_idle();
        req_valid = 1'b0; req_is_write = 1'b0; req_addr = '0; req_data = '0;
        req_length = '0; req_first_be = '0; req_last_be = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        rx_header = '0; rx_data = '0;
    endtask

    task automatic set_req(input bit wr, input logic [63:0] addr, input logic [9:0] len,
                           input logic [255:0] data);
        req_valid = 1'b1; req_is_write = wr; req_addr = addr; req_length = len;
        req_first_be = 4'hF; req_last_be = (len > 1) ? 4'hF : 4'h0; req_data = data;
    endtask

    task automatic set_rx(input logic [2:0] fmt, input int tag, input logic [255:0] data);
        rx_valid = 1'b1; rx_sop = 1'b1; rx_eop = 1'b1;
        rx_header = mk_cpl(fmt, 5'b01010, tag); rx_data = data;
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin m_pend[t] = 1'b0; m_alloc[t] = 0; m_wr[t] = 1'b0; end
        m_txv = 1'b0; m_txh = '0; m_txd = '0;
    endtask

    // One clock: predict from model and current inputs, clock the DUT, compare everything.
    task automatic tick();
        bit any_free, rdy, acc, is_cpl, match, rv, e_wr, e_err;
        int alloc, tg, to_tag;
        logic [2:0] fmt;
        logic [1:0] e_st;
        logic [255:0] e_data;
        #1;
        any_free = 1'b0; alloc = 0;
        for (int t = NT - 1; t >= 0; t--)
            if (!m_pend[t]) begin any_free = 1'b1; alloc = t; end
        rdy = (!m_txv || tx_ready) && any_free;
        check("req_ready", req_ready, rdy);
        acc = req_valid && rdy;
        fmt = rx_header[127:125];
        tg  = int'(rx_header[81:72]);
        is_cpl = rx_valid && rx_sop && (rx_header[124:120] == 5'b01010) &&
                 (fmt == 3'b000 || fmt == 3'b010);
        match = 1'b0;
        if (is_cpl && tg < NT)
            match = m_pend[tg] && ((fmt == 3'b010) == !m_wr[tg]);
        rv = 1'b0; tg = match ? tg : 0; e_wr = 1'b0; e_st = 2'b00; e_data = '0; to_tag = -1;
        if (match) begin
            rv = 1'b1; e_wr = m_wr[tg]; e_data = (fmt == 3'b010) ? rx_data : '0;
            m_pend[tg] = 1'b0;
        end else begin
            for (int t = NT - 1; t >= 0; t--)
                if (m_pend[t] && (edge_no + 1 - m_alloc[t]) >= TO) to_tag = t;
            if (to_tag >= 0) begin
                rv = 1'b1; tg = to_tag; e_wr = m_wr[to_tag]; e_st = 2'b01;
                m_pend[to_tag] = 1'b0;
            end
        end
        e_err = is_cpl && !match;
        if (acc) begin
            m_pend[alloc] = 1'b1; m_alloc[alloc] = edge_no + 1; m_wr[alloc] = req_is_write;
            m_txv = 1'b1;
            m_txh = mk_hdr(req_is_write, req_addr, req_length, req_first_be, req_last_be, alloc);
            m_txd = req_is_write ? req_data : '0;
        end else if (tx_ready) begin
            m_txv = 1'b0;
        end
        @(posedge clk); #1;
        edge_no++;
        check("tx_valid", tx_valid, m_txv);
        if (m_txv) begin
            check("tx_sop", tx_sop, 1'b1);
            check("tx_eop", tx_eop, 1'b1);
            check("tx_header", tx_header, m_txh);
            check("tx_data", tx_data, m_txd);
        end
        check("rsp_valid", rsp_valid, rv);
        if (rv) begin
            check("rsp_tag", rsp_tag, tg);
            check("rsp_status", rsp_status, e_st);
            check("rsp_is_write", rsp_is_write, e_wr);
            check("rsp_data", rsp_data, e_data);
        end
        check("err_unexp_cpl", err_unexp_cpl, e_err);
        check("outstanding_cnt", outstanding_cnt, model_cnt());
    endtask

    task automatic drain();
        int n = 0;
        set_idle();
        while ((model_cnt() != 0 || m_txv) && n < 64) begin tick(); n++; end
        check("drain_done", model_cnt(), 0);
    endtask

    typedef struct {
        bit           wr;
        logic [63:0]  addr;
        logic [9:0]   len;
        logic [255:0] data;
        logic [7:0]   exp_fmt_type;
        logic [2:0]   cpl_fmt;
        bit           exp_err;
        logic [255:0] exp_rsp_data;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [255:0] a5;
        logic [255:0] wdat;
        int n;
        bit got;

        a5 = {32{8'hA5}};
        wdat = rand256();
        vecs[0] = '{1'b1, 64'h10, 10'd1, a5, 8'h40, 3'b000, 1'b0, '0};
        vecs[1] = '{1'b0, 64'h10, 10'd1, '0, 8'h00, 3'b010, 1'b0, a5};
        vecs[2] = '{1'b0, 64'hDEAD_BEEF_0000_1000, 10'd8, '0, 8'h00, 3'b000, 1'b1, '0};
        vecs[3] = '{1'b1, 64'h20, 10'd2, wdat, 8'h40, 3'b010, 1'b1, '0};

        set_idle();
        model_reset();
        rst_n = 1'b0;
        #23;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_err", err_unexp_cpl, 1'b0);
        check("rst_cnt", outstanding_cnt, 0);
        check("rst_req_ready", req_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Header encoding and completion matching from the table.
        for (int v = 0; v < 4; v++) begin
            drain();
            set_req(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].data);
            tick();
            set_idle();
            check("vec_fmt_type", tx_header[127:120], vecs[v].exp_fmt_type);
            check("vec_req_id", tx_header[97:82], 16'h0100);
            check("vec_tag", tx_header[81:72], 0);
            check("vec_addr", tx_header[63:0], vecs[v].addr);
            set_rx(vecs[v].cpl_fmt, 0, a5);
            tick();
            set_idle();
            check("vec_err", err_unexp_cpl, vecs[v].exp_err);
            check("vec_rsp_valid", rsp_valid, !vecs[v].exp_err);
            if (!vecs[v].exp_err) begin
                check("vec_rsp_status", rsp_status, 2'b00);
                check("vec_rsp_is_write", rsp_is_write, vecs[v].wr);
                check("vec_rsp_data", rsp_data, vecs[v].exp_rsp_data);
            end
        end

        // Fill all tags, free tag 3, and expect it to be reused next.
        drain();
        for (int i = 0; i < NT; i++) begin
            set_req(1'b0, 64'(i * 256), 10'd1, '0);
            tick();
            check("t3_tag", tx_header[81:72], i);
        end
        #1;
        check("t3_ready_full", req_ready, 1'b0);
        check("t3_cnt_full", outstanding_cnt, NT);
        tick();
        set_idle();
        set_rx(3'b010, 3, rand256());
        tick();
        set_idle();
        set_req(1'b0, 64'h3000, 10'd1, '0);
        #1;
        check("t3_ready_freed", req_ready, 1'b1);
        tick();
        check("t3_reuse_tag", tx_header[81:72], 3);
        drain();

        // TX backpressure: header held, no accept, then transfer plus same-cycle accept.
        tx_ready = 1'b0;
        set_req(1'b0, 64'h1000, 10'd1, '0);
        tick();
        check("t4_valid", tx_valid, 1'b1);
        set_req(1'b1, 64'h2000, 10'd1, wdat);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_ready_stall", req_ready, 1'b0);
            tick();
            check("t4_hold_addr", tx_header[63:0], 64'h1000);
            check("t4_hold_valid", tx_valid, 1'b1);
        end
        tx_ready = 1'b1;
        #1;
        check("t4_ready_release", req_ready, 1'b1);
        tick();
        check("t4_new_addr", tx_header[63:0], 64'h2000);
        check("t4_new_data", tx_data, wdat);
        check("t4_new_tag", tx_header[81:72], 1);

        // Unexpected completions: free tag, and Cpl for a pending read.
        set_idle();
        set_rx(3'b010, 5, rand256());
        tick();
        check("t5_err_free_tag", err_unexp_cpl, 1'b1);
        check("t5_cnt_free_tag", outstanding_cnt, 2);
        set_rx(3'b000, 0, '0);
        tick();
        check("t5_err_wrong_fmt", err_unexp_cpl, 1'b1);
        check("t5_cnt_wrong_fmt", outstanding_cnt, 2);
        drain();

        // Timeout lands exactly TO edges after accept; a late CplD is unexpected.
        set_req(1'b0, 64'h40, 10'd1, '0);
        tick();
        set_idle();
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (rsp_valid) got = 1'b1;
        end
        check("t6_to_latency", n, TO);
        check("t6_status", rsp_status, 2'b01);
        check("t6_tag", rsp_tag, 0);
        set_rx(3'b010, 0, rand256());
        tick();
        set_idle();
        check("t6_late_cpl_err", err_unexp_cpl, 1'b1);

        // Mid-operation reset drops outstanding tags without responses.
        for (int i = 0; i < 3; i++) begin
            set_req(1'(i), 64'(i), 10'd1, rand256());
            tick();
        end
        set_idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", outstanding_cnt, 0);
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) tick();

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            int r;
            logic [2:0] fmt;
            req_valid    = 1'($urandom_range(0, 1));
            req_is_write = 1'($urandom_range(0, 1));
            req_addr     = {$urandom(), $urandom()};
            req_data     = rand256();
            req_length   = 10'($urandom());
            req_first_be = 4'($urandom());
            req_last_be  = 4'($urandom());
            tx_ready     = ($urandom_range(0, 3) != 0);
            rx_valid     = ($urandom_range(0, 2) == 0);
            r   = $urandom_range(0, 9);
            fmt = (r < 5) ? 3'b010 : (r < 9) ? 3'b000 : 3'b001;
            rx_header = mk_cpl(fmt, ($urandom_range(0, 9) == 0) ? 5'b00000 : 5'b01010,
                               $urandom_range(0, 9));
            rx_data = rand256();
            rx_sop  = ($urandom_range(0, 9) != 0);
            rx_eop  = rx_sop;
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
